// File: rtl/uart_tx_fifo.sv
// Byte FIFO that paces writes into a busy-less UART transmitter.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH           = 16,
  parameter int CHAR_GAP_CYCLES = 4800
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     uart_we,
  output logic [7:0]               uart_data,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(CHAR_GAP_CYCLES) + 1;

  typedef enum logic {
    IDLE,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_nx;
  logic [7:0]    mem [DEPTH];
  logic          we_nx;
  logic [7:0]    data_nx;
  logic          pop;
  logic          push;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign idle  = empty & (state == IDLE) & ~uart_we;
  // a pop frees a slot in the same cycle, so a full FIFO still takes it
  assign push  = wr_en & (~full | pop);

  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    we_nx    = 1'b0;
    data_nx  = uart_data;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          we_nx    = 1'b1;
          data_nx  = mem[rd_ptr];
          pop      = 1'b1;
          gap_nx   = GW'(CHAR_GAP_CYCLES - 1);
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap == '0) state_nx = IDLE;
        else gap_nx = gap - GW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap       <= '0;
      uart_we   <= 1'b0;
      uart_data <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      gap       <= gap_nx;
      uart_we   <= we_nx;
      uart_data <= data_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (wr_en & full & ~pop) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule
